// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with Z/N/V/C flags; shifts and multiply iterate one step per cycle.
// The first iteration step happens on the accept edge, so an n-step op completes n edges after accept.
module seq_alu #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] H,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             ERR
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_SHL = 4'h4;
    localparam logic [3:0] OP_SHR = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_ASR = 4'h8;
    localparam logic [3:0] OP_ROL = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    localparam logic [SHW-1:0]   W_CNT = SHW'(WIDTH);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] lo_q, hi_q, mcand_q;
    logic [SHW-1:0]   cnt_q;

    logic             accept;
    logic [3:0]       cur_op;
    logic [WIDTH-1:0] src_lo, src_hi, src_m;
    logic [SHW-1:0]   src_cnt, shamt;
    logic [WIDTH-1:0] step_lo, step_hi;
    logic             step_c;
    logic [WIDTH:0]   sum_m, arith;
    logic             iterative, fin;
    logic [WIDTH-1:0] res_d, res_h;
    logic             res_c, res_v, res_err;

    // Handshake: valid/ready both sides; a transfer happens on any edge where both are high.
    assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);

    always_comb begin
        shamt = '0;
        if (S == OP_ROL)
            shamt = SHW'(B % W_VAL);
        else if (B >= W_VAL)
            shamt = W_CNT;
        else
            shamt = SHW'(B);
    end

    // On accept the step operates on the fresh operands, otherwise on the working registers.
    always_comb begin
        cur_op    = accept ? S : op_q;
        src_lo    = accept ? ((S == OP_MUL) ? B : A) : lo_q;
        src_hi    = accept ? '0 : hi_q;
        src_m     = accept ? A : mcand_q;
        src_cnt   = accept ? ((S == OP_MUL) ? W_CNT : shamt) : cnt_q;
        iterative = (cur_op inside {OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_MUL});
        sum_m     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);

        step_lo = src_lo;
        step_hi = src_hi;
        step_c  = 1'b0;
        case (cur_op)
            OP_SHL: begin step_c = src_lo[WIDTH-1]; step_lo = {src_lo[WIDTH-2:0], 1'b0}; end
            OP_SHR: begin step_c = src_lo[0]; step_lo = {1'b0, src_lo[WIDTH-1:1]}; end
            OP_ASR: begin step_c = src_lo[0]; step_lo = {src_lo[WIDTH-1], src_lo[WIDTH-1:1]}; end
            OP_ROL: begin step_c = src_lo[WIDTH-1]; step_lo = {src_lo[WIDTH-2:0], src_lo[WIDTH-1]}; end
            OP_MUL: begin step_hi = sum_m[WIDTH:1]; step_lo = {sum_m[0], src_lo[WIDTH-1:1]}; end
            default: ;
        endcase

        fin     = 1'b1;
        arith   = '0;
        res_d   = '0;
        res_h   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        if (iterative && src_cnt != '0) begin
            fin   = (src_cnt == SHW'(1));
            res_d = step_lo;
            if (cur_op == OP_MUL) begin
                res_h = step_hi;
                res_c = |step_hi;
            end else begin
                res_c = step_c;
            end
        end else begin
            case (cur_op)
                OP_ADD: begin
                    arith = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
                    res_d = arith[WIDTH-1:0];
                    res_c = arith[WIDTH];
                    res_v = (A[WIDTH-1] == B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
                end
                OP_SUB: begin
                    arith = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};
                    res_d = arith[WIDTH-1:0];
                    res_c = arith[WIDTH];
                    res_v = (A[WIDTH-1] != B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
                end
                OP_AND: res_d = A & B;
                OP_OR:  res_d = A | B;
                OP_XOR: res_d = A ^ B;
                OP_NOT: res_d = ~A;
                OP_SHL, OP_SHR, OP_ASR, OP_ROL: res_d = A;
                default: res_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            D       <= '0;
            H       <= '0;
            C       <= 1'b0;
            Z       <= 1'b0;
            N       <= 1'b0;
            V       <= 1'b0;
            ERR     <= 1'b0;
        end else if (accept || state == BUSY) begin
            op_q    <= cur_op;
            lo_q    <= step_lo;
            hi_q    <= step_hi;
            mcand_q <= src_m;
            cnt_q   <= src_cnt - SHW'(1);
            if (fin) begin
                state <= DONE;
                D     <= res_d;
                H     <= res_h;
                C     <= res_c;
                Z     <= (res_d == '0);
                N     <= res_d[WIDTH-1];
                V     <= res_v;
                ERR   <= res_err;
            end else begin
                state <= BUSY;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): directed cases plus random ops against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 8;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] h;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       err;
        int         lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, D, H;
    logic [3:0]   S;
    logic         Cin, C, Z, N, V, ERR;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .S(S), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .H(H), .C(C), .Z(Z), .N(N), .V(V), .ERR(ERR)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                                   input logic ci);
        exp_t e;
        int ua, ub, sa, sb, c, n, t;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = ci ? 1 : 0;
        e = '0;
        e.lat = 1;
        n = (ub > 8) ? 8 : ub;
        case (s)
            4'h0: begin
                t = ua + ub + c; e.d = 8'(t); e.c = (t > 255);
                t = sa + sb + c; e.v = (t > 127) || (t < -128);
            end
            4'h1: begin
                t = ua - ub - c; e.d = 8'(t); e.c = (ua < ub + c);
                t = sa - sb - c; e.v = (t > 127) || (t < -128);
            end
            4'h2: e.d = a & b;
            4'h3: e.d = a | b;
            4'h6: e.d = a ^ b;
            4'h7: e.d = ~a;
            4'h4: begin
                e.d = 8'(ua << n); e.c = (n > 0) && (((ua >> (8 - n)) & 1) == 1);
                e.lat = (n == 0) ? 1 : n;
            end
            4'h5: begin
                e.d = 8'(ua >> n); e.c = (n > 0) && (((ua >> (n - 1)) & 1) == 1);
                e.lat = (n == 0) ? 1 : n;
            end
            4'h8: begin
                e.d = 8'(sa >>> n); e.c = (n > 0) && (((sa >>> (n - 1)) & 1) == 1);
                e.lat = (n == 0) ? 1 : n;
            end
            4'h9: begin
                n = ub % 8;
                e.d = 8'((ua << n) | (ua >> (8 - n))); e.c = (n > 0) && e.d[0];
                e.lat = (n == 0) ? 1 : n;
            end
            4'hA: begin
                t = ua * ub; e.d = 8'(t); e.h = 8'(t >> 8); e.c = (e.h != 8'h00); e.lat = 8;
            end
            default: e.err = 1'b1;
        endcase
        e.z = (e.d == 8'h00);
        e.n = e.d[7];
        return e;
    endfunction

    // Driver: issue one op, measure latency, check result, optionally hold it under backpressure.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s, input logic ci, input int stall);
        exp_t e;
        int lat;
        e = model(a, b, s, ci);
        exp_q.push_back(e.d);
        @(negedge clk);
        out_ready = (stall == 0);
        in_valid = 1'b1; A = a; B = b; S = s; Cin = ci;
        #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); S = 4'($urandom); Cin = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(e.lat));
        check({tag, ".D"}, 32'(D), 32'(exp_q.pop_front()));
        check({tag, ".H"}, 32'(H), 32'(e.h));
        check({tag, ".C"}, 32'(C), 32'(e.c));
        check({tag, ".Z"}, 32'(Z), 32'(e.z));
        check({tag, ".N"}, 32'(N), 32'(e.n));
        check({tag, ".V"}, 32'(V), 32'(e.v));
        check({tag, ".ERR"}, 32'(ERR), 32'(e.err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".hold_D"}, 32'(D), 32'(e.d));
            check({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        logic seen;
        logic [7:0] rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; S = '0; Cin = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.D", 32'(D), 32'd0);
        check("rst.H", 32'(H), 32'd0);
        check("rst.flags", 32'({C, Z, N, V, ERR}), 32'd0);
        rst_n = 1'b1;
        #1 check("rst.idle_ready", 32'(in_ready), 32'd1);

        do_op("add_ff_01", 8'hFF, 8'h01, 4'h0, 1'b0, 0);
        do_op("sub_80_01", 8'h80, 8'h01, 4'h1, 1'b0, 0);
        do_op("sub_00_00_c", 8'h00, 8'h00, 4'h1, 1'b1, 0);
        do_op("shl_81_3", 8'h81, 8'h03, 4'h4, 1'b0, 0);
        do_op("shr_81_1", 8'h81, 8'h01, 4'h5, 1'b0, 0);
        do_op("shl_81_9", 8'h81, 8'h09, 4'h4, 1'b0, 0);
        do_op("shr_81_0", 8'h81, 8'h00, 4'h5, 1'b0, 0);
        do_op("asr_80_2", 8'h80, 8'h02, 4'h8, 1'b0, 0);
        do_op("asr_c5_200", 8'hC5, 8'd200, 4'h8, 1'b0, 0);
        do_op("rol_81_1", 8'h81, 8'h01, 4'h9, 1'b0, 0);
        do_op("rol_81_9", 8'h81, 8'h09, 4'h9, 1'b0, 0);
        do_op("mul_10_10", 8'h10, 8'h10, 4'hA, 1'b0, 0);
        do_op("mul_0f_0f", 8'h0F, 8'h0F, 4'hA, 1'b0, 0);

        // Backpressure: ADD result held, then a back-to-back XOR accepted on release.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; A = 8'h7F; B = 8'h01; S = 4'h0; Cin = 1'b1;
        @(posedge clk);
        #1 A = 8'h55; B = 8'h0F; S = 4'h6; Cin = 1'b0;
        @(negedge clk);
        check("bp.valid", 32'(out_valid), 32'd1);
        check("bp.D", 32'(D), 32'h81);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_D", 32'(D), 32'h81);
            check("bp.hold_flags", 32'({C, Z, N, V, ERR}), 32'b00110);
            check("bp.hold_rdy", 32'(in_ready), 32'd0);
            check("bp.hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1 check("bp.release_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp.b2b_valid", 32'(out_valid), 32'd1);
        check("bp.b2b_D", 32'(D), 32'h5A);

        // Reset in the middle of a multiply.
        do_op("mul_ff_ff", 8'hFF, 8'hFF, 4'hA, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1; A = 8'h10; B = 8'h10; S = 4'hA; Cin = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("midrst.in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.D", 32'(D), 32'd0);
        check("midrst.H", 32'(H), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst.no_stale", 32'(seen), 32'd0);

        do_op("rsv_c", 8'h5A, 8'h33, 4'hC, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            do_op($sformatf("rnd%0d", i), 8'($urandom), rb, 4'($urandom_range(0, 15)),
                  1'($urandom), $urandom_range(0, 2));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
